// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
package hazard_stall_unit_pkg;

  localparam int HZ_REGISTER_BITS      = 5;
  localparam int HZ_MD_LATENCY_DEFAULT = 4;
  localparam int HZ_STAT_BITS_DEFAULT  = 16;

  // Interlock FSM: normal flow, or EX held by a multi-cycle MUL/DIV.
  typedef enum logic {
    HZ_RUN     = 1'b0,
    HZ_MD_BUSY = 1'b1
  } hz_state_e;

  // Bundle of every per-stage control the unit drives.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic ex_mem_bubble;
    logic md_busy;
    logic md_done;
  } hz_ctrl_t;

  // Controls while the pipeline is held in reset: nothing advances, NOPs injected.
  function automatic hz_ctrl_t hz_ctrl_reset();
    hz_ctrl_t c;
    c               = '0;
    c.id_ex_bubble  = 1'b1;
    c.ex_mem_bubble = 1'b1;
    return c;
  endfunction

  // Controls for an unobstructed cycle: every stage advances.
  function automatic hz_ctrl_t hz_ctrl_run();
    hz_ctrl_t c;
    c              = '0;
    c.pc_write     = 1'b1;
    c.if_id_write  = 1'b1;
    c.id_ex_write  = 1'b1;
    c.ex_mem_write = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_counter.sv
// Saturating event counter used for stall and flush performance statistics.
module hz_event_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Count up on inc, sticking at all-ones so a long run never wraps to small values.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline interlock controller: resolves load-use, taken-branch, MUL/DIV occupancy
// and data-memory wait hazards with stage write-enables, bubbles and flushes.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REGISTER_BITS = HZ_REGISTER_BITS,
  parameter int MD_LATENCY    = HZ_MD_LATENCY_DEFAULT,
  parameter int STAT_BITS     = HZ_STAT_BITS_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [REGISTER_BITS-1:0] IF_ID_RS,
  input  logic [REGISTER_BITS-1:0] IF_ID_RT,
  input  logic                     IF_ID_UseRT,
  input  logic [REGISTER_BITS-1:0] ID_EX_RT,
  input  logic                     ID_EX_MemRead,
  input  logic                     ID_EX_MulDiv,
  input  logic                     EX_BranchTaken,
  input  logic                     DMEM_Stall,
  output logic                     PC_Write,
  output logic                     IF_ID_Write,
  output logic                     IF_ID_Flush,
  output logic                     ID_EX_Write,
  output logic                     ID_EX_Bubble,
  output logic                     EX_MEM_Write,
  output logic                     EX_MEM_Bubble,
  output logic                     MD_Busy,
  output logic                     MD_Done,
  output logic [STAT_BITS-1:0]     Stall_Count,
  output logic [STAT_BITS-1:0]     Flush_Count
);

  // The entry cycle is the first of MD_LATENCY, the counted MD_BUSY cycles follow.
  localparam int                  MD_CNT_W = $clog2(MD_LATENCY);
  localparam logic [MD_CNT_W-1:0] MD_LOAD  = MD_CNT_W'(MD_LATENCY - 2);

  hz_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  hz_ctrl_t            ctrl;
  logic                load_use;
  logic                flush_inc;
  logic                stall_inc;

  // Load-use: EX load writes a register the ID instruction reads; r0 is never a hazard.
  assign load_use = ID_EX_MemRead && (ID_EX_RT != '0) &&
                    ((ID_EX_RT == IF_ID_RS) || (IF_ID_UseRT && (ID_EX_RT == IF_ID_RT)));

  // Priority-ordered hazard resolution; outputs take effect in the same cycle.
  always_comb begin
    state_d   = state_q;
    md_cnt_d  = md_cnt_q;
    ctrl      = hz_ctrl_run();
    flush_inc = 1'b0;
    if (DMEM_Stall) begin
      // Memory wait freezes everything, including MD progress and MD entry.
      ctrl.pc_write      = 1'b0;
      ctrl.if_id_write   = 1'b0;
      ctrl.id_ex_write   = 1'b0;
      ctrl.ex_mem_write  = 1'b0;
      ctrl.ex_mem_bubble = 1'b1;
    end else if (state_q == HZ_MD_BUSY) begin
      ctrl.pc_write      = 1'b0;
      ctrl.if_id_write   = 1'b0;
      ctrl.id_ex_write   = 1'b0;
      ctrl.ex_mem_bubble = 1'b1;
      if (md_cnt_q == '0) begin
        // Final cycle: the result moves on into EX/MEM.
        ctrl.md_done       = 1'b1;
        ctrl.ex_mem_bubble = 1'b0;
        state_d            = HZ_RUN;
      end else begin
        md_cnt_d = md_cnt_q - MD_CNT_W'(1);
      end
    end else if (ID_EX_MulDiv) begin
      ctrl.pc_write      = 1'b0;
      ctrl.if_id_write   = 1'b0;
      ctrl.id_ex_write   = 1'b0;
      ctrl.ex_mem_bubble = 1'b1;
      state_d            = HZ_MD_BUSY;
      md_cnt_d           = MD_LOAD;
    end else if (EX_BranchTaken) begin
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_bubble = 1'b1;
      flush_inc         = 1'b1;
    end else if (load_use) begin
      ctrl.pc_write     = 1'b0;
      ctrl.if_id_write  = 1'b0;
      ctrl.id_ex_bubble = 1'b1;
    end
    ctrl.md_busy = (state_q == HZ_MD_BUSY);
    if (!rst_n) begin
      ctrl      = hz_ctrl_reset();
      flush_inc = 1'b0;
    end
  end

  // FSM state and MD occupancy counter; reset aborts any MUL/DIV in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HZ_RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign stall_inc = rst_n && !ctrl.pc_write;

  hz_event_counter #(.W(STAT_BITS)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (Stall_Count)
  );

  hz_event_counter #(.W(STAT_BITS)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (Flush_Count)
  );

  assign PC_Write      = ctrl.pc_write;
  assign IF_ID_Write   = ctrl.if_id_write;
  assign IF_ID_Flush   = ctrl.if_id_flush;
  assign ID_EX_Write   = ctrl.id_ex_write;
  assign ID_EX_Bubble  = ctrl.id_ex_bubble;
  assign EX_MEM_Write  = ctrl.ex_mem_write;
  assign EX_MEM_Bubble = ctrl.ex_mem_bubble;
  assign MD_Busy       = ctrl.md_busy;
  assign MD_Done       = ctrl.md_done;

endmodule
